// File: rtl/burst_dram_slave.sv
// Burst-capable word-addressed memory slave with independent read and write channels.
// Read and write FSMs run concurrently; the memory array has a registered, read-first port.
module burst_dram_slave #(
  parameter int    DATA_W    = 64,
  parameter int    ADDR_W    = 13,
  parameter int    DEPTH     = 8192,
  parameter int    LEN_W     = 4,
  parameter int    RD_LAT    = 2,
  parameter int    WR_LAT    = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ar_valid,
  input  logic [ADDR_W-1:0]   i_ar_addr,
  input  logic [LEN_W-1:0]    i_ar_len,
  output logic                o_ar_ready,
  output logic                o_r_valid,
  output logic [DATA_W-1:0]   o_r_data,
  output logic [1:0]          o_r_resp,
  output logic                o_r_last,
  input  logic                i_r_ready,
  input  logic                i_aw_valid,
  input  logic [ADDR_W-1:0]   i_aw_addr,
  input  logic [LEN_W-1:0]    i_aw_len,
  output logic                o_aw_ready,
  input  logic                i_w_valid,
  input  logic [DATA_W-1:0]   i_w_data,
  input  logic [DATA_W/8-1:0] i_w_strb,
  input  logic                i_w_last,
  output logic                o_w_ready,
  output logic                o_b_valid,
  output logic [1:0]          o_b_resp,
  input  logic                i_b_ready
);
  localparam int STRB_W = DATA_W / 8;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RC_W   = $clog2(RD_LAT + 1);
  localparam int WC_W   = $clog2(WR_LAT + 1);

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_BEAT} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_BEAT, WR_RESP} wr_state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Keeps both address-ready outputs low during the reset cycle itself.
  logic              r_rst_done;
  rd_state_t         r_rd_state, w_rd_state_next;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [LEN_W-1:0]  r_rd_len, r_rd_beat;
  logic [RC_W-1:0]   r_rd_wait;
  logic [DATA_W-1:0] r_rd_q;
  logic              r_rd_ok, r_rd_err, r_rd_last;
  wr_state_t         r_wr_state, w_wr_state_next;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [LEN_W-1:0]  r_wr_len, r_wr_beat;
  logic [WC_W-1:0]   r_wr_wait;
  logic              r_wr_err;

  logic              w_ar_fire, w_r_fire, w_aw_fire, w_w_fire, w_b_fire;
  logic              w_rd_wait_done, w_wr_wait_done, w_rd_load, w_rd_in_range, w_wr_in_range;
  logic [ADDR_W-1:0] w_rd_load_addr;
  logic [LEN_W-1:0]  w_rd_next_beat;

  assign w_ar_fire      = i_ar_valid & o_ar_ready;
  assign w_r_fire       = o_r_valid & i_r_ready;
  assign w_aw_fire      = i_aw_valid & o_aw_ready;
  assign w_w_fire       = i_w_valid & o_w_ready;
  assign w_b_fire       = o_b_valid & i_b_ready;
  assign w_rd_wait_done = (r_rd_state == RD_WAIT) && (r_rd_wait == RC_W'(RD_LAT - 1));
  assign w_wr_wait_done = (r_wr_state == WR_WAIT) && (r_wr_wait == WC_W'(WR_LAT - 1));

  // A beat is loaded either at the end of the wait or right after a non-last beat is taken.
  assign w_rd_load      = w_rd_wait_done || ((r_rd_state == RD_BEAT) && w_r_fire && !r_rd_last);
  assign w_rd_load_addr = (r_rd_state == RD_WAIT) ? r_rd_addr : r_rd_addr + 1'b1;
  assign w_rd_next_beat = (r_rd_state == RD_WAIT) ? '0 : r_rd_beat + 1'b1;
  assign w_rd_in_range  = {1'b0, w_rd_load_addr} < (ADDR_W + 1)'(DEPTH);
  assign w_wr_in_range  = {1'b0, r_wr_addr} < (ADDR_W + 1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_done <= 1'b0;
      r_rd_state <= RD_IDLE;
      r_wr_state <= WR_IDLE;
    end else begin
      r_rst_done <= 1'b1;
      r_rd_state <= w_rd_state_next;
      r_wr_state <= w_wr_state_next;
    end
  end

  always_comb begin
    w_rd_state_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (w_ar_fire) w_rd_state_next = RD_WAIT;
      RD_WAIT: if (w_rd_wait_done) w_rd_state_next = RD_BEAT;
      RD_BEAT: if (w_r_fire && r_rd_last) w_rd_state_next = RD_IDLE;
      default: w_rd_state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    w_wr_state_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: if (w_aw_fire) w_wr_state_next = WR_WAIT;
      WR_WAIT: if (w_wr_wait_done) w_wr_state_next = WR_BEAT;
      WR_BEAT: if (w_w_fire && (r_wr_beat == r_wr_len)) w_wr_state_next = WR_RESP;
      WR_RESP: if (w_b_fire) w_wr_state_next = WR_IDLE;
      default: w_wr_state_next = WR_IDLE;
    endcase
  end

  always_comb begin
    o_ar_ready = (r_rd_state == RD_IDLE) && r_rst_done;
    o_r_valid  = (r_rd_state == RD_BEAT);
    o_r_data   = r_rd_ok ? r_rd_q : '0;
    o_r_resp   = r_rd_err ? 2'b10 : 2'b00;
    o_r_last   = r_rd_last;
    o_aw_ready = (r_wr_state == WR_IDLE) && r_rst_done;
    o_w_ready  = (r_wr_state == WR_BEAT);
    o_b_valid  = (r_wr_state == WR_RESP);
    o_b_resp   = ((r_wr_state == WR_RESP) && r_wr_err) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_rd_len  <= '0;
      r_rd_beat <= '0;
      r_rd_wait <= '0;
      r_rd_ok   <= 1'b0;
      r_rd_err  <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      if (w_ar_fire) begin
        r_rd_addr <= i_ar_addr;
        r_rd_len  <= i_ar_len;
        r_rd_wait <= '0;
      end else if (r_rd_state == RD_WAIT) begin
        r_rd_wait <= r_rd_wait + 1'b1;
      end
      if (w_rd_load) begin
        r_rd_addr <= w_rd_load_addr;
        r_rd_beat <= w_rd_next_beat;
        r_rd_last <= (w_rd_next_beat == r_rd_len);
        r_rd_ok   <= w_rd_in_range;
        r_rd_err  <= !w_rd_in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr <= '0;
      r_wr_len  <= '0;
      r_wr_beat <= '0;
      r_wr_wait <= '0;
      r_wr_err  <= 1'b0;
    end else begin
      if (w_aw_fire) begin
        r_wr_addr <= i_aw_addr;
        r_wr_len  <= i_aw_len;
        r_wr_beat <= '0;
        r_wr_wait <= '0;
        r_wr_err  <= 1'b0;
      end else if (r_wr_state == WR_WAIT) begin
        r_wr_wait <= r_wr_wait + 1'b1;
      end
      if (w_w_fire) begin
        r_wr_addr <= r_wr_addr + 1'b1;
        r_wr_beat <= r_wr_beat + 1'b1;
        if (!w_wr_in_range || (i_w_last != (r_wr_beat == r_wr_len))) r_wr_err <= 1'b1;
      end
      if (w_b_fire) r_wr_err <= 1'b0;
    end
  end

  // Read and write share the array; nonblocking update makes a same-edge read see old data.
  always_ff @(posedge clk) begin
    if (w_rd_load && w_rd_in_range) r_rd_q <= r_mem[w_rd_load_addr[MEM_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (w_w_fire && w_wr_in_range) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (i_w_strb[i]) r_mem[r_wr_addr[MEM_AW-1:0]][i*8 +: 8] <= i_w_data[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_burst_dram_slave.sv
// Scoreboard bench for burst_dram_slave: stimulus pushes expected beats/responses,
// a negedge monitor compares R and B channel outputs against a byte-level memory model.
module tb_burst_dram_slave;
  localparam int DW = 64, AW = 13, DEPTH = 8191, LW = 4, RD_LAT = 2, WR_LAT = 2;
  localparam int NWORDS = 8192;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic          ar_valid = 0, ar_ready, r_valid, r_ready = 0, r_last;
  logic [AW-1:0] ar_addr = '0, aw_addr = '0;
  logic [LW-1:0] ar_len = '0, aw_len = '0;
  logic [DW-1:0] r_data, w_data = '0;
  logic [1:0]    r_resp, b_resp;
  logic          aw_valid = 0, aw_ready, w_valid = 0, w_last = 0, w_ready, b_valid, b_ready = 0;
  logic [7:0]    w_strb = '0;

  burst_dram_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LEN_W(LW),
                     .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .i_ar_valid(ar_valid), .i_ar_addr(ar_addr), .i_ar_len(ar_len), .o_ar_ready(ar_ready),
    .o_r_valid(r_valid), .o_r_data(r_data), .o_r_resp(r_resp), .o_r_last(r_last), .i_r_ready(r_ready),
    .i_aw_valid(aw_valid), .i_aw_addr(aw_addr), .i_aw_len(aw_len), .o_aw_ready(aw_ready),
    .i_w_valid(w_valid), .i_w_data(w_data), .i_w_strb(w_strb), .i_w_last(w_last), .o_w_ready(w_ready),
    .o_b_valid(b_valid), .o_b_resp(b_resp), .i_b_ready(b_ready)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [63:0] mask;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  int checks = 0, failures = 0;
  rbeat_t rq[$];
  logic [1:0] bq[$];
  int rmode = 0, rd_done = 0, wr_done = 0;
  bit ar_chk = 0, aw_chk = 0;
  logic [63:0] mdat [NWORDS];
  logic [63:0] mmask [NWORDS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout/unexpected expected handshake", name);
  endtask

  // R/B monitor and ready generator; rmode 0=always, 1=random, 2=never, 3=toggle.
  initial forever begin
    @(negedge clk);
    if (ar_chk) begin chk("ar_ready_after_last", ar_ready, 1); ar_chk = 0; end
    if (aw_chk) begin chk("aw_ready_after_b", aw_ready, 1); aw_chk = 0; end
    case (rmode)
      0: r_ready = 1'b1;
      1: r_ready = 1'($urandom_range(0, 1));
      2: r_ready = 1'b0;
      default: r_ready = ~r_ready;
    endcase
    b_ready = ($urandom_range(0, 2) == 0);
    if (rst) begin
      rq.delete();
      bq.delete();
      ar_chk = 0;
      aw_chk = 0;
    end else begin
      if (r_valid) begin
        if (rq.size() == 0) fail("unexpected_r_beat");
        else begin
          chk("r_data", r_data & rq[0].mask, rq[0].data & rq[0].mask);
          chk("r_resp", r_resp, rq[0].resp);
          chk("r_last", r_last, rq[0].last);
          if (r_ready) begin
            if (rq[0].last) begin rd_done++; ar_chk = 1; end
            void'(rq.pop_front());
          end
        end
      end
      if (b_valid) begin
        if (bq.size() == 0) fail("unexpected_b");
        else begin
          chk("b_resp", b_resp, bq[0]);
          if (b_ready) begin wr_done++; aw_chk = 1; void'(bq.pop_front()); end
        end
      end
    end
  end

  task automatic push_read(input int addr, input int len);
    rbeat_t b;
    int a;
    for (int i = 0; i <= len; i++) begin
      a = (addr + i) % NWORDS;
      if (a >= DEPTH) begin b.data = '0; b.mask = '1; b.resp = 2'b10; end
      else begin b.data = mdat[a]; b.mask = mmask[a]; b.resp = 2'b00; end
      b.last = (i == len);
      rq.push_back(b);
    end
  endtask

  task automatic model_write(input int a, input logic [7:0] st, input logic [63:0] d);
    if (a < DEPTH)
      for (int k = 0; k < 8; k++)
        if (st[k]) begin mdat[a][k*8 +: 8] = d[k*8 +: 8]; mmask[a][k*8 +: 8] = 8'hFF; end
  endtask

  task automatic do_read(input int addr, input int len);
    int t, start;
    push_read(addr, len);
    start = rd_done;
    ar_valid = 1; ar_addr = AW'(addr); ar_len = LW'(len);
    t = 0;
    while (!ar_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail("ar_handshake_timeout");
    @(posedge clk); @(negedge clk);
    ar_valid = 0;
    chk("ar_ready_in_wait", ar_ready, 0);
    t = 0;
    while (!r_valid && t < 50) begin @(negedge clk); t++; end
    chk("first_r_latency", t, RD_LAT);
    t = 0;
    while (rd_done == start && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) fail("read_burst_timeout");
    $display("RD addr=%0d len=%0d", addr, len);
  endtask

  // last_at < 0 means W_LAST on the final beat; otherwise W_LAST only on beat last_at.
  task automatic do_write(input int addr, input int len, input logic [7:0] strb0,
                          input bit rnd, input int last_at);
    int t, start, a;
    logic [1:0] er;
    bit wl;
    logic [7:0] st;
    logic [63:0] d;
    er = 2'b00;
    for (int i = 0; i <= len; i++) begin
      a = (addr + i) % NWORDS;
      wl = (last_at < 0) ? (i == len) : (i == last_at);
      if (a >= DEPTH || wl != (i == len)) er = 2'b10;
    end
    bq.push_back(er);
    start = wr_done;
    aw_valid = 1; aw_addr = AW'(addr); aw_len = LW'(len);
    t = 0;
    while (!aw_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail("aw_handshake_timeout");
    @(posedge clk); @(negedge clk);
    aw_valid = 0;
    chk("aw_ready_in_wait", aw_ready, 0);
    for (int i = 0; i <= len; i++) begin
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
      a = (addr + i) % NWORDS;
      wl = (last_at < 0) ? (i == len) : (i == last_at);
      st = rnd ? 8'($urandom) : ((i == 0) ? strb0 : 8'hFF);
      d = {$urandom, $urandom};
      w_valid = 1; w_data = d; w_strb = st; w_last = wl;
      t = 0;
      while (!w_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) fail("w_beat_timeout");
      @(posedge clk);
      model_write(a, st, d);
      @(negedge clk);
      w_valid = 0;
    end
    t = 0;
    while (wr_done == start && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) fail("b_response_timeout");
    $display("WR addr=%0d len=%0d resp=%0d", addr, len, er);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_r_resp", r_resp, 0);
    chk("rst_r_last", r_last, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_resp", b_resp, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t, rs, ws, base, len;
    logic [63:0] d;
    for (int i = 0; i < NWORDS; i++) begin mdat[i] = '0; mmask[i] = '0; end
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 0;
    @(negedge clk);
    chk("ready_after_reset_ar", ar_ready, 1);
    chk("ready_after_reset_aw", aw_ready, 1);

    rmode = 0;
    do_write(5, 0, 8'hFF, 0, -1);
    do_write(8190, 3, 8'hFF, 0, -1);
    do_write(20, 0, 8'hFF, 0, -1);
    do_read(5, 0);
    rmode = 3;
    do_read(8190, 3);
    rmode = 1;
    do_write(10, 1, 8'h0F, 0, -1);
    do_read(10, 1);
    do_write(12, 2, 8'hFF, 0, 1);
    do_write(15, 0, 8'hFF, 0, -1);
    do_read(12, 3);

    // Read beat of word 20 is loaded on the same edge as the write to it.
    rmode = 0;
    push_read(20, 0);
    bq.push_back(2'b00);
    rs = rd_done; ws = wr_done;
    d = {$urandom, $urandom};
    aw_valid = 1; aw_addr = 20; aw_len = 0;
    w_valid = 1; w_data = d; w_strb = 8'hFF; w_last = 1;
    t = 0;
    while (!aw_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail("conc_aw_timeout");
    @(posedge clk); @(negedge clk);
    aw_valid = 0;
    ar_valid = 1; ar_addr = 20; ar_len = 0;
    chk("conc_ar_ready", ar_ready, 1);
    @(posedge clk); @(negedge clk);
    ar_valid = 0;
    t = 0;
    while (!w_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail("conc_w_timeout");
    @(posedge clk);
    model_write(20, 8'hFF, d);
    @(negedge clk);
    w_valid = 0;
    t = 0;
    while ((rd_done == rs || wr_done == ws) && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) fail("conc_done_timeout");
    $display("RD+WR concurrent addr=20");
    do_read(20, 0);

    rmode = 1;
    for (int n = 0; n < 40; n++) begin
      base = $urandom_range(0, 1) ? $urandom_range(0, 63) : $urandom_range(8176, 8191);
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1)
        do_write(base, len, 8'hFF, 1, ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1);
      else
        do_read(base, len);
    end

    // Reset with both FSMs mid-burst.
    rmode = 2;
    push_read(40, 7);
    ar_valid = 1; ar_addr = 40; ar_len = 7;
    t = 0;
    while (!ar_ready && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); @(negedge clk);
    ar_valid = 0;
    aw_valid = 1; aw_addr = 30; aw_len = 7;
    t = 0;
    while (!aw_ready && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); @(negedge clk);
    aw_valid = 0;
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      w_valid = 1; w_data = d; w_strb = 8'hFF; w_last = 0;
      t = 0;
      while (!w_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) fail("rstmid_w_timeout");
      @(posedge clk);
      model_write(30 + i, 8'hFF, d);
      @(negedge clk);
      w_valid = 0;
    end
    t = 0;
    while (!r_valid && t < 50) begin @(negedge clk); t++; end
    chk("rstmid_r_beat_active", r_valid, 1);
    chk("rstmid_w_beat_active", w_ready, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); @(negedge clk);
    chk_reset_outputs();
    rst = 0;
    rmode = 1;
    repeat (20) @(negedge clk);
    $display("RST mid-burst");
    do_read(30, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
